// File: rtl/dispatch_reg_axil_bridge.sv
// Purpose:      AXI4-Lite slave -> dispatcher register bus (addr/data/valid/ack), one access in flight.
// Latency:      ready cycle -> BVALID/RVALID 2 cycles minimum (1 strobe cycle with immediate ack).
// Backpressure: B/R responses held until BREADY/RREADY; no new AW/W/AR accepted until then.
//
// Ports: iClock/iReset (async, active-low); AXI4-Lite slave AW/W/B/AR/R channels (iS_*/oS_*);
//        register-bus write side oWriteAddress/oWriteData/oWriteValid/iWriteAck and read side
//        oReadAddress/oReadValid/iReadAck/iReadData.
// Build option: DRB_WRITE_ACK_WAIT_EN -- when defined, writes wait for iWriteAck (or time out
//        with SLVERR); when undefined, writes are posted as a one-cycle oWriteValid pulse.
module dispatch_reg_axil_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [AXI_ADDR_WIDTH-1:0] iS_AWADDR,
    input  logic                      iS_AWVALID,
    output logic                      oS_AWREADY,
    input  logic [31:0]               iS_WDATA,
    input  logic                      iS_WVALID,
    output logic                      oS_WREADY,
    output logic [1:0]                oS_BRESP,
    output logic                      oS_BVALID,
    input  logic                      iS_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] iS_ARADDR,
    input  logic                      iS_ARVALID,
    output logic                      oS_ARREADY,
    output logic [31:0]               oS_RDATA,
    output logic [1:0]                oS_RRESP,
    output logic                      oS_RVALID,
    input  logic                      iS_RREADY,
    output logic [31:0]               oWriteAddress,
    output logic [31:0]               oWriteData,
    output logic                      oWriteValid,
    input  logic                      iWriteAck,
    output logic [31:0]               oReadAddress,
    input  logic [31:0]               iReadData,
    output logic                      oReadValid,
    input  logic                      iReadAck
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires during the last strobe cycle.
    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_RESP
    } state_t;

    state_t        state, state_n;
    logic          aw_rdy, aw_rdy_n;      // drives both AWREADY and WREADY
    logic          ar_rdy, ar_rdy_n;
    logic          bvalid, bvalid_n;
    logic [1:0]    bresp, bresp_n;
    logic          rvalid, rvalid_n;
    logic [31:0]   rdata, rdata_n;
    logic [1:0]    rresp, rresp_n;
    logic [31:0]   wr_addr, wr_addr_n;
    logic [31:0]   wr_data, wr_data_n;
    logic          wr_vld, wr_vld_n;
    logic [31:0]   rd_addr, rd_addr_n;
    logic          rd_vld, rd_vld_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_wr, last_wr_n;    // 1: last served access was a write

    logic          wr_pick;
    logic          timed_out;
    logic [CW-1:0] cnt_inc;

    // Write wins only if both AW and W are present and, when a read also waits, reads went last.
    assign wr_pick   = iS_AWVALID & iS_WVALID & (~iS_ARVALID | ~last_wr);
    assign timed_out = (cnt >= CNT_LAST);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

`ifndef DRB_WRITE_ACK_WAIT_EN
    // Posted writes never look at the ack; the name keeps it visibly intentional.
    logic unused_write_ack;
    assign unused_write_ack = iWriteAck;
`endif

    always_comb begin
        state_n   = state;
        aw_rdy_n  = 1'b0;
        ar_rdy_n  = 1'b0;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        wr_vld_n  = wr_vld;
        rd_addr_n = rd_addr;
        rd_vld_n  = rd_vld;
        cnt_n     = cnt;
        last_wr_n = last_wr;

        case (state)
            IDLE: begin
                // A raised ready means the handshake completes this cycle; start the bus access.
                if (aw_rdy) begin
                    state_n  = WR_ISSUE;
                    wr_vld_n = 1'b1;
                    cnt_n    = '0;
                end else if (ar_rdy) begin
                    state_n  = RD_ISSUE;
                    rd_vld_n = 1'b1;
                    cnt_n    = '0;
                end else if (wr_pick) begin
                    aw_rdy_n  = 1'b1;
                    wr_addr_n = 32'(iS_AWADDR);
                    wr_data_n = iS_WDATA;
                    last_wr_n = 1'b1;
                end else if (iS_ARVALID) begin
                    ar_rdy_n  = 1'b1;
                    rd_addr_n = 32'(iS_ARADDR);
                    last_wr_n = 1'b0;
                end
            end

            WR_ISSUE: begin
`ifdef DRB_WRITE_ACK_WAIT_EN
                if (iWriteAck) begin
                    wr_vld_n = 1'b0;
                    bvalid_n = 1'b1;
                    bresp_n  = RESP_OKAY;
                    state_n  = WR_RESP;
                end else if (timed_out) begin
                    wr_vld_n = 1'b0;
                    bvalid_n = 1'b1;
                    bresp_n  = RESP_SLVERR;
                    state_n  = WR_RESP;
                end else begin
                    cnt_n = cnt_inc;
                end
`else
                // The core's trigger decode is level-sensitive: strobe exactly one cycle.
                wr_vld_n = 1'b0;
                bvalid_n = 1'b1;
                bresp_n  = RESP_OKAY;
                state_n  = WR_RESP;
`endif
            end

            WR_RESP: begin
                if (iS_BREADY) begin
                    bvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end

            RD_ISSUE: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (iReadAck) begin
                    rd_vld_n = 1'b0;
                    rvalid_n = 1'b1;
                    rdata_n  = iReadData;
                    rresp_n  = RESP_OKAY;
                    state_n  = RD_RESP;
                end else if (timed_out) begin
                    rd_vld_n = 1'b0;
                    rvalid_n = 1'b1;
                    rdata_n  = '0;
                    rresp_n  = RESP_SLVERR;
                    state_n  = RD_RESP;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            RD_RESP: begin
                if (iS_RREADY) begin
                    rvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state   <= IDLE;
            aw_rdy  <= 1'b0;
            ar_rdy  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_vld  <= 1'b0;
            rd_addr <= '0;
            rd_vld  <= 1'b0;
            cnt     <= '0;
            last_wr <= 1'b0;
        end else begin
            state   <= state_n;
            aw_rdy  <= aw_rdy_n;
            ar_rdy  <= ar_rdy_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            wr_vld  <= wr_vld_n;
            rd_addr <= rd_addr_n;
            rd_vld  <= rd_vld_n;
            cnt     <= cnt_n;
            last_wr <= last_wr_n;
        end
    end

    assign oS_AWREADY    = aw_rdy;
    assign oS_WREADY     = aw_rdy;
    assign oS_ARREADY    = ar_rdy;
    assign oS_BVALID     = bvalid;
    assign oS_BRESP      = bresp;
    assign oS_RVALID     = rvalid;
    assign oS_RDATA      = rdata;
    assign oS_RRESP      = rresp;
    assign oWriteAddress = wr_addr;
    assign oWriteData    = wr_data;
    assign oWriteValid   = wr_vld;
    assign oReadAddress  = rd_addr;
    assign oReadValid    = rd_vld;

endmodule

// File: tb/tb_dispatch_reg_axil_bridge.sv
// Purpose:      scoreboard bench for dispatch_reg_axil_bridge (directed vectors).
// Latency:      expected strobe lengths and ready->response latencies are computed per access.
// Backpressure: BREADY/RREADY are dropped in places to exercise response holding.
module tb_dispatch_reg_axil_bridge;

    localparam int TO = 16;
    localparam int K_BUSW = 0;
    localparam int K_BUSR = 1;
    localparam int K_B    = 2;
    localparam int K_R    = 3;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic [31:0] iS_AWADDR = '0;
    logic        iS_AWVALID = 1'b0;
    logic        oS_AWREADY;
    logic [31:0] iS_WDATA = '0;
    logic        iS_WVALID = 1'b0;
    logic        oS_WREADY;
    logic [1:0]  oS_BRESP;
    logic        oS_BVALID;
    logic        iS_BREADY = 1'b1;
    logic [31:0] iS_ARADDR = '0;
    logic        iS_ARVALID = 1'b0;
    logic        oS_ARREADY;
    logic [31:0] oS_RDATA;
    logic [1:0]  oS_RRESP;
    logic        oS_RVALID;
    logic        iS_RREADY = 1'b1;
    logic [31:0] oWriteAddress;
    logic [31:0] oWriteData;
    logic        oWriteValid;
    logic        iWriteAck = 1'b0;
    logic [31:0] oReadAddress;
    logic [31:0] iReadData = '0;
    logic        oReadValid;
    logic        iReadAck = 1'b0;

    dispatch_reg_axil_bridge #(.AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .iClock(iClock), .iReset(iReset),
        .iS_AWADDR(iS_AWADDR), .iS_AWVALID(iS_AWVALID), .oS_AWREADY(oS_AWREADY),
        .iS_WDATA(iS_WDATA), .iS_WVALID(iS_WVALID), .oS_WREADY(oS_WREADY),
        .oS_BRESP(oS_BRESP), .oS_BVALID(oS_BVALID), .iS_BREADY(iS_BREADY),
        .iS_ARADDR(iS_ARADDR), .iS_ARVALID(iS_ARVALID), .oS_ARREADY(oS_ARREADY),
        .oS_RDATA(oS_RDATA), .oS_RRESP(oS_RRESP), .oS_RVALID(oS_RVALID), .iS_RREADY(iS_RREADY),
        .oWriteAddress(oWriteAddress), .oWriteData(oWriteData), .oWriteValid(oWriteValid),
        .iWriteAck(iWriteAck),
        .oReadAddress(oReadAddress), .iReadData(iReadData), .oReadValid(oReadValid),
        .iReadAck(iReadAck)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_delay = 0;     // ack in this strobe cycle (1-based); 0 = never ack
    int          wr_delay = 0;
    logic [31:0] rd_src = '0;
    int          cyc = 0;
    int          awready_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push(input int kind, input logic [31:0] a, input logic [31:0] b, input int n);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.n = n;
        exp_q.push_back(e);
    endfunction

    // Expected register-bus strobe and B response for one write.
    function automatic void push_wr(input logic [31:0] a, input logic [31:0] d, input int ack);
`ifdef DRB_WRITE_ACK_WAIT_EN
        if (ack > 0) begin
            push(K_BUSW, a, d, ack);
            push(K_B, 32'h0, 32'h0, ack + 1);
        end else begin
            push(K_BUSW, a, d, TO);
            push(K_B, 32'h2, 32'h0, TO + 1);
        end
`else
        push(K_BUSW, a, d, 1 + 0 * ack);
        push(K_B, 32'h0, 32'h0, 2);
`endif
    endfunction

    function automatic void push_rd(input logic [31:0] a, input logic [31:0] d, input int ack);
        if (ack > 0) begin
            push(K_BUSR, a, 32'h0, ack);
            push(K_R, 32'h0, d, ack + 1);
        end else begin
            push(K_BUSR, a, 32'h0, TO);
            push(K_R, 32'h2, 32'h0, TO + 1);
        end
    endfunction

    function automatic void got(input int kind, input logic [31:0] a, input logic [31:0] b, input int n);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_a",    a, e.a);
            check("event_b",    b, e.b);
            check("event_len_or_latency", 32'(n), 32'(e.n));
        end
    endfunction

    // Register-core responder.
    initial begin
        int rc;
        int wc;
        rc = 0;
        wc = 0;
        forever begin
            @(negedge iClock);
            if (oReadValid) begin
                rc++;
                iReadAck  = (rc == rd_delay);
                iReadData = (rc == rd_delay) ? rd_src : 32'h0BAD_0BAD;
            end else begin
                rc = 0;
                iReadAck = 1'b0;
            end
            if (oWriteValid) begin
                wc++;
                iWriteAck = (wc == wr_delay);
            end else begin
                wc = 0;
                iWriteAck = 1'b0;
            end
        end
    end

    // Monitor: turns DUT activity into events and checks them against the queue.
    initial begin
        int          wlen;
        int          rlen;
        int          aw_c;
        int          ar_c;
        int          blat;
        int          rlat;
        logic        bv_prev;
        logic        rv_prev;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        wlen = 0; rlen = 0; aw_c = 0; ar_c = 0; blat = 0; rlat = 0;
        bv_prev = 1'b0; rv_prev = 1'b0; wa = '0; wd = '0; ra = '0;
        forever begin
            @(negedge iClock);
            #2;
            cyc++;
            if (!iReset) begin
                wlen = 0; rlen = 0; bv_prev = 1'b0; rv_prev = 1'b0;
                continue;
            end
            if (oS_AWREADY) begin
                aw_c = cyc;
                awready_cnt++;
            end
            if (oS_ARREADY) ar_c = cyc;
            if (oWriteValid) begin
                if (wlen == 0) begin
                    wa = oWriteAddress;
                    wd = oWriteData;
                end
                wlen++;
            end else if (wlen > 0) begin
                got(K_BUSW, wa, wd, wlen);
                wlen = 0;
            end
            if (oReadValid) begin
                if (rlen == 0) ra = oReadAddress;
                rlen++;
            end else if (rlen > 0) begin
                got(K_BUSR, ra, 32'h0, rlen);
                rlen = 0;
            end
            if (oS_BVALID && !bv_prev) blat = cyc - aw_c;
            if (oS_BVALID && iS_BREADY) got(K_B, 32'(oS_BRESP), 32'h0, blat);
            bv_prev = oS_BVALID;
            if (oS_RVALID && !rv_prev) rlat = cyc - ar_c;
            if (oS_RVALID && iS_RREADY) got(K_R, 32'(oS_RRESP), oS_RDATA, rlat);
            rv_prev = oS_RVALID;
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int t;
        iS_AWADDR = a; iS_WDATA = d; iS_AWVALID = 1'b1; iS_WVALID = 1'b1;
        t = 0;
        do begin
            @(negedge iClock);
            t++;
        end while (!oS_AWREADY && t < 100);
        check("awready_seen", 32'(oS_AWREADY), 32'h1);
        @(negedge iClock);
        iS_AWVALID = 1'b0; iS_WVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int t;
        iS_ARADDR = a; iS_ARVALID = 1'b1;
        t = 0;
        do begin
            @(negedge iClock);
            t++;
        end while (!oS_ARREADY && t < 100);
        check("arready_seen", 32'(oS_ARREADY), 32'h1);
        @(negedge iClock);
        iS_ARVALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge iClock);
            t++;
        end
        repeat (2) @(negedge iClock);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(oS_AWREADY), 32'h0);
        check({tag, "_wready"},  32'(oS_WREADY),  32'h0);
        check({tag, "_arready"}, 32'(oS_ARREADY), 32'h0);
        check({tag, "_bvalid"},  32'(oS_BVALID),  32'h0);
        check({tag, "_bresp"},   32'(oS_BRESP),   32'h0);
        check({tag, "_rvalid"},  32'(oS_RVALID),  32'h0);
        check({tag, "_rdata"},   oS_RDATA,        32'h0);
        check({tag, "_rresp"},   32'(oS_RRESP),   32'h0);
        check({tag, "_wvalid"},  32'(oWriteValid), 32'h0);
        check({tag, "_waddr"},   oWriteAddress,   32'h0);
        check({tag, "_wdata"},   oWriteData,      32'h0);
        check({tag, "_rvalid_bus"}, 32'(oReadValid), 32'h0);
        check({tag, "_raddr"},   oReadAddress,    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(negedge iClock);
        #1;
        check_all_zero("reset");
        @(negedge iClock);
        iReset = 1'b1;
        @(negedge iClock);

        // Simultaneous read+write after reset: write first, then the pending read beats a new write.
        wr_delay = 0;
        rd_delay = 1;
        rd_src   = 32'h1111_2222;
        push_wr(32'h10, 32'hA5A5_0001, 0);
        push_rd(32'h20, 32'h1111_2222, 1);
        push_wr(32'h14, 32'hA5A5_0002, 0);
        fork
            do_read(32'h20);
            begin
                do_write(32'h10, 32'hA5A5_0001);
                do_write(32'h14, 32'hA5A5_0002);
            end
        join
        drain();

        // Posted write to the trigger address.
        push_wr(32'h0, 32'h1234, 0);
        do_write(32'h0, 32'h1234);
        drain();

        // Read acked in its third strobe cycle.
        rd_delay = 3;
        rd_src   = 32'hCAFE_F00D;
        push_rd(32'h8, 32'hCAFE_F00D, 3);
        do_read(32'h8);
        drain();

        // Read never acked: timeout with SLVERR and zero data.
        rd_delay = 0;
        push_rd(32'hC, 32'h0, 0);
        do_read(32'hC);
        drain();

        // Write acked in its second strobe cycle, with B backpressure.
        wr_delay  = 2;
        iS_BREADY = 1'b0;
        push_wr(32'h4, 32'h0000_BEEF, 2);
        do_write(32'h4, 32'h0000_BEEF);
        repeat (25) @(negedge iClock);
        check("bvalid_held", 32'(oS_BVALID), 32'h1);
        iS_BREADY = 1'b1;
        drain();
        wr_delay = 0;

        // Immediate read ack with R backpressure: minimum latency and held data.
        rd_delay  = 1;
        rd_src    = 32'h5A5A_C3C3;
        iS_RREADY = 1'b0;
        push_rd(32'h24, 32'h5A5A_C3C3, 1);
        do_read(32'h24);
        repeat (5) @(negedge iClock);
        check("rvalid_held", 32'(oS_RVALID), 32'h1);
        check("rdata_held",  oS_RDATA, 32'h5A5A_C3C3);
        iS_RREADY = 1'b1;
        drain();

        // AW without W is never accepted; supplying W later completes it.
        iS_AWADDR  = 32'h18;
        iS_AWVALID = 1'b1;
        c0 = awready_cnt;
        repeat (10) @(negedge iClock);
        check("aw_without_w_ready", 32'(awready_cnt), 32'(c0));
        check("aw_without_w_strobe", 32'(oWriteValid), 32'h0);
        push_wr(32'h18, 32'h77, 0);
        do_write(32'h18, 32'h77);
        drain();

        // Reset in the middle of a read: everything drops at once, no response afterwards.
        rd_delay = 0;
        do_read(32'h30);
        repeat (4) @(negedge iClock);
        check("mid_read_strobe", 32'(oReadValid), 32'h1);
        iReset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge iClock);
        iReset = 1'b1;
        repeat (30) @(negedge iClock);
        check("no_rvalid_after_reset", 32'(oS_RVALID), 32'h0);

        // Recovery access.
        rd_delay = 2;
        rd_src   = 32'h0F0F_1234;
        push_rd(32'h34, 32'h0F0F_1234, 2);
        do_read(32'h34);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
